// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage. Owns the PC, sequences instruction-memory
//               requests with a req/ready handshake, and redirects on PCSel.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int             n         = 32,
    parameter logic [n-1:0]   RESET_PC  = '0,
    parameter logic [n-1:0]   NOP_INSTR = 'h13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PCSel,
    input  logic [n-1:0] alu_result,
    input  logic         stall,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic [n-1:0] imem_rdata,
    input  logic         imem_ready,
    output logic [n-1:0] instr,
    output logic         instr_valid,
    output logic [n-1:0] pc,
    output logic [n-1:0] pc_plus4,
    output logic         misalign_err
);

    localparam logic [n-1:0] c_four = n'(4);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t       r_state;
    logic [n-1:0] r_pc;
    logic [n-1:0] r_instr;
    logic         r_err;

    logic [n-1:0] w_pc_plus4;
    logic [n-1:0] w_next;
    logic         w_aligned;

    assign w_pc_plus4 = r_pc + c_four;
    assign w_next     = PCSel ? alu_result : w_pc_plus4;
    assign w_aligned  = (w_next[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        r_instr <= NOP_INSTR;
                        if (w_aligned) begin
                            r_pc    <= w_next;
                            r_state <= S_REQ;
                        end else begin
                            // pc keeps the faulting instruction's address
                            r_err   <= 1'b1;
                            r_state <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    // Gating with rst drops the request the instant reset asserts.
    assign imem_req     = !rst && ((r_state == S_REQ) || (r_state == S_WAIT));
    assign imem_addr    = r_pc;
    assign instr        = r_instr;
    assign instr_valid  = (r_state == S_ISSUE);
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign misalign_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSel;
    logic [31:0] alu_result;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch #(
        .n         (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PCSel        (PCSel),
        .alu_result   (alu_result),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    // Small program image; the memory returns the word at whatever address is presented.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0040_0793;
            32'h0000_0004: mem_word = 32'h0010_0813;
            32'h0000_0008: mem_word = 32'h0005_8663;
            32'h0000_0014: mem_word = 32'h00a0_0513;
            32'h0000_0018: mem_word = 32'h0000_0463;
            default:       mem_word = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; PCSel = 1'b0; alu_result = '0; stall = 1'b0; imem_ready = 1'b1;
        #2;
        chk("rst_req",   {31'd0, imem_req},     32'd0);
        chk("rst_valid", {31'd0, instr_valid},  32'd0);
        chk("rst_err",   {31'd0, misalign_err}, 32'd0);
        chk("rst_pc",    pc,                    32'h0000_0000);
        chk("rst_instr", instr,                 32'h0000_0013);
        chk("rst_pc4",   pc_plus4,              32'h0000_0004);

        // Zero-wait fetches at 0, 4, 8
        @(negedge clk); rst = 1'b0; #1;
        chk("zw_req0",  {31'd0, imem_req}, 32'd1);
        chk("zw_addr0", imem_addr,         32'h0000_0000);
        tick();
        chk("zw_valid0", {31'd0, instr_valid}, 32'd1);
        chk("zw_instr0", instr,                32'h0040_0793);
        chk("zw_noreq0", {31'd0, imem_req},    32'd0);
        tick();
        chk("zw_addr4",   imem_addr,             32'h0000_0004);
        chk("zw_novalid", {31'd0, instr_valid},  32'd0);
        tick();
        chk("zw_valid4", {31'd0, instr_valid}, 32'd1);
        chk("zw_instr4", instr,                32'h0010_0813);
        tick();
        chk("zw_addr8", imem_addr, 32'h0000_0008);
        tick();

        // Taken branch from pc=8 to 0x14
        chk("br_instr", instr,    32'h0005_8663);
        chk("br_pc",    pc,       32'h0000_0008);
        chk("br_pc4",   pc_plus4, 32'h0000_000C);
        PCSel = 1'b1; alu_result = 32'h0000_0014;
        tick();
        chk("br_addr", imem_addr, 32'h0000_0014);
        PCSel = 1'b0;

        // Wait-state fetch: ready arrives in the 4th request cycle
        imem_ready = 1'b0;
        chk("ws_req0", {31'd0, imem_req}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("ws_req",   {31'd0, imem_req},    32'd1);
            chk("ws_addr",  imem_addr,            32'h0000_0014);
            chk("ws_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        tick();
        chk("ws_validup", {31'd0, instr_valid}, 32'd1);
        chk("ws_instr",   instr,                32'h00a0_0513);

        // Stall holds instr/pc; redirect request ignored while stalled
        stall = 1'b1; PCSel = 1'b1; alu_result = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_valid", {31'd0, instr_valid}, 32'd1);
            chk("st_pc",    pc,                   32'h0000_0014);
            chk("st_instr", instr,                32'h00a0_0513);
        end
        stall = 1'b0; PCSel = 1'b0;
        tick();
        chk("st_next", imem_addr, 32'h0000_0018);
        tick();

        // Misaligned redirect halts the fetch stage
        PCSel = 1'b1; alu_result = 32'h0000_0022;
        tick();
        PCSel = 1'b0;
        chk("ma_err",   {31'd0, misalign_err}, 32'd1);
        chk("ma_valid", {31'd0, instr_valid},  32'd0);
        chk("ma_req",   {31'd0, imem_req},     32'd0);
        chk("ma_pc",    pc,                    32'h0000_0018);
        chk("ma_instr", instr,                 32'h0000_0013);
        tick();
        chk("ma_err2",   {31'd0, misalign_err}, 32'd1);
        chk("ma_req2",   {31'd0, imem_req},     32'd0);
        chk("ma_pc2",    pc,                    32'h0000_0018);
        chk("ma_instr2", instr,                 32'h0000_0013);

        // Async reset between edges clears the halt
        #4; rst = 1'b1; #1;
        chk("ar_err", {31'd0, misalign_err}, 32'd0);
        chk("ar_pc",  pc,                    32'h0000_0000);
        chk("ar_req", {31'd0, imem_req},     32'd0);
        #1; rst = 1'b0; imem_ready = 1'b0;
        tick();
        chk("aw_req",  {31'd0, imem_req}, 32'd1);
        chk("aw_addr", imem_addr,         32'h0000_0000);

        // Async reset mid-WAIT drops the request before the next edge
        #4; rst = 1'b1; #1;
        chk("aw_rstreq",   {31'd0, imem_req},    32'd0);
        chk("aw_rstvalid", {31'd0, instr_valid}, 32'd0);
        #2; rst = 1'b0; imem_ready = 1'b1; #1;
        chk("rf_req",  {31'd0, imem_req}, 32'd1);
        chk("rf_addr", imem_addr,         32'h0000_0000);
        tick();
        chk("rf_valid", {31'd0, instr_valid}, 32'd1);
        chk("rf_instr", instr,                32'h0040_0793);

        // pc+4 wraps at the top of the address space without error
        PCSel = 1'b1; alu_result = 32'hFFFF_FFFC;
        tick();
        PCSel = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wr_pc4",  pc_plus4,  32'h0000_0000);
        tick();
        chk("wr_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        chk("wr_addr0", imem_addr,             32'h0000_0000);
        chk("wr_noerr", {31'd0, misalign_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the control decoder: owns the program counter, issues requests to instruction memory, and presents the fetched word on instr to the control unit and immediate generator.
- Consumes PCSel and the ALU result (branch/jump target) back from execute, so the next PC is chosen per retired instruction.
- Instruction memory may take a variable number of cycles, so a req/ready handshake and a small FSM sequence each fetch.

Parameters:
- n, 32, data/address width (XLEN).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on instr when no valid fetch is held (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCSel  in  1  0: next PC = pc+4; 1: next PC = alu_result.
- alu_result  in  n  branch/jump target from ALU.
- stall  in  1  hold current instruction; no PC update.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  n  fetch address; equals pc while imem_req is high.
- imem_rdata  in  n  instruction word, valid when imem_ready is high.
- imem_ready  in  1  memory response strobe; ignored unless imem_req is high.
- instr  out  n  instruction to the control unit.
- instr_valid  out  1  instr holds a fetched, not-yet-retired instruction.
- pc  out  n  address of instr.
- pc_plus4  out  n  pc + 4, for WBSel link writeback.
- misalign_err  out  1  sticky: redirect target not word-aligned.

Behaviour:
- The reset is asynchronous. Asserting rst immediately forces:
  - state=REQ, pc=RESET_PC, instr=NOP_INSTR;
  - instr_valid=0, imem_req=0, misalign_err=0.
- The first imem_req rises in the first cycle after rst deasserts.
- The FSM has four states: REQ, WAIT, ISSUE, HALT.
- REQ:
  - Drive imem_req=1 and imem_addr=pc.
  - If imem_ready=1 in the same cycle: latch imem_rdata into instr and go to ISSUE. This is the zero-wait case, with 1-cycle fetch latency.
  - Otherwise go to WAIT.
- WAIT:
  - imem_req stays 1 and imem_addr stays stable until imem_ready.
  - On imem_ready: latch imem_rdata into instr and go to ISSUE.
- ISSUE:
  - Drive instr_valid=1 and imem_req=0.
  - If stall=1: hold instr, pc and instr_valid, and remain in ISSUE. PCSel and alu_result are ignored.
  - If stall=0: compute next = PCSel ? alu_result : pc+4.
    - If next[1:0]==2'b00: pc<=next, instr_valid<=0, instr<=NOP_INSTR, go to REQ.
    - Otherwise: misalign_err<=1, instr_valid<=0, instr<=NOP_INSTR, go to HALT, and pc keeps the faulting instruction's address.
- HALT: imem_req=0 and instr_valid=0; the FSM stays here until rst.
- Throughput: one instruction per 2 cycles with zero-wait memory (REQ+ISSUE), plus 1 cycle per wait cycle.
- pc+4 wraps modulo 2^n (32'hFFFF_FFFC -> 32'h0000_0000). Wrap is not an error.
- pc_plus4 is combinational pc+4 and is valid in every state.
- stall is don't-care outside ISSUE: a fetch in flight completes regardless.
- imem_ready asserted while imem_req=0 is ignored; instr is not overwritten.
- Reset mid-WAIT drops imem_req asynchronously. A later stale imem_ready is ignored because the FSM is in REQ with a fresh request.

Test Plan:
- Reset release, zero-wait memory (imem_ready=1 always):
  - imem_addr = 0, 4, 8 on successive REQ cycles.
  - instr_valid pulses every 2nd cycle.
  - instr = 32'h00400793 at pc=0.
- Wait-state memory (imem_ready after 3 cycles):
  - imem_req held 4 cycles with imem_addr=0 stable.
  - instr_valid rises the cycle after ready.
- Taken branch:
  - In ISSUE with pc=8, instr=32'h00058663, PCSel=1, alu_result=32'h14.
  - Next imem_addr=32'h14; pc_plus4 was 32'hC during ISSUE.
- Stall:
  - stall=1 for 3 cycles in ISSUE with PCSel=1, alu_result=32'h40, then stall=0 with PCSel=0.
  - instr and pc are held during the stall; next pc = old pc+4, not 32'h40.
- Misaligned target:
  - PCSel=1, alu_result=32'h22.
  - misalign_err=1, instr_valid=0, imem_req=0 permanently; pc unchanged until rst.
- Async reset mid-WAIT:
  - rst pulse between clock edges.
  - imem_req, instr_valid and misalign_err go to 0 before the next edge; pc=RESET_PC; refetch at 0.
